// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes; define SEQ_ALU_DIV_EN to add the iterative divider.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);
`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
  state_t           state, state_nx, start_st;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] acc, opa, opb, step_acc, step_opa, step_opb, fin;
  logic [WIDTH-1:0] bx, sum, short_res;
  logic             sub, add_ovf, short_ovf, accept, last;
  assign accept    = in_valid && in_ready;
  assign last      = cnt == (SHW+1)'(WIDTH-1);
  assign sub       = alucontrol == 4'b0001 || alucontrol == 4'b0101;
  assign bx        = sub ? ~b : b;
  assign sum       = a + bx + WIDTH'(sub);
  assign add_ovf   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign short_ovf = (alucontrol == 4'b0000 || alucontrol == 4'b0001) && add_ovf;
  assign zero      = result == '0;
  always_comb begin
    case (alucontrol)
      4'b0000, 4'b0001: short_res = sum;
      4'b0010: short_res = a & b;
      4'b0011: short_res = a | b;
      4'b0100: short_res = a ^ b;
      4'b0101: short_res = WIDTH'(sum[WIDTH-1] ^ add_ovf);
      4'b0110: short_res = WIDTH'(a < b);
      4'b0111: short_res = a << b[SHW-1:0];
      4'b1000: short_res = a >> b[SHW-1:0];
      4'b1001: short_res = WIDTH'($signed(a) >>> b[SHW-1:0]);
      default: short_res = '0;
    endcase
  end
`ifdef SEQ_ALU_DIV_EN
  logic             is_rem, ge;
  logic [WIDTH:0]   sh;
  assign sh       = {acc, opa[WIDTH-1]};
  assign ge       = sh >= {1'b0, opb};
  assign start_st = alucontrol == 4'b1010 ? MUL :
                    (alucontrol == 4'b1011 || alucontrol == 4'b1100) ? DIV : DONE;
  assign fin      = (state == DIV && !is_rem) ? step_opa : step_acc;
`else
  assign start_st = alucontrol == 4'b1010 ? MUL : DONE;
  assign fin      = step_acc;
`endif
  // Multiplier: acc accumulates, opa is the shifted multiplicand, opb the shifted multiplier.
  // Divider: acc is the partial remainder, opa shifts the dividend out and the quotient in.
  always_comb begin
    step_acc = acc + (opb[0] ? opa : '0);
    step_opa = opa << 1;
    step_opb = opb >> 1;
`ifdef SEQ_ALU_DIV_EN
    if (state == DIV) begin
      step_acc = ge ? WIDTH'(sh - {1'b0, opb}) : sh[WIDTH-1:0];
      step_opa = {opa[WIDTH-2:0], ge};
      step_opb = opb;
    end
`endif
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      MUL: state_nx = last ? DONE : MUL;
`ifdef SEQ_ALU_DIV_EN
      DIV: state_nx = last ? DONE : DIV;
`endif
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = state;
    endcase
    if (accept) state_nx = start_st;
  end
  always_comb begin
    out_valid = state == DONE;
    in_ready  = state == IDLE || (out_valid && out_ready);
    busy      = !(state == IDLE || state == DONE);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt      <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      result   <= '0;
      overflow <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      is_rem   <= 1'b0;
`endif
    end else if (accept) begin
      cnt      <= '0;
      acc      <= '0;
      opa      <= a;
      opb      <= b;
      result   <= short_res;
      overflow <= short_ovf;
`ifdef SEQ_ALU_DIV_EN
      is_rem   <= alucontrol == 4'b1100;
`endif
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      acc <= step_acc;
      opa <= step_opa;
      opb <= step_opb;
      if (last) result <= fin;
    end
endmodule
